muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the execute stage, beside the ALU. It takes the same ID/EX operand pair and runs MULT, MULTU, DIV and DIVU over 34 cycles. Results go to the architectural HI/LO registers held here. HI/LO are read back through the ALU-side result mux (MFHI/MFLO). `busy` stalls the pipeline front end.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   op encodings, FSM state type, divide-by-zero LO value and op-decode helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  localparam logic [31:0] DIVZERO_LO = 32'hFFFFFFFF;

  function automatic logic op_is_div(input logic [1:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Each operation takes 34 cycles: IDLE accept, 32 CALC bit-steps, 1 FIX cycle.
// Ports:
//   clock, reset       - rising-edge clock, asynchronous active-high reset
//   a, b               - rs/rt operands (multiplicand/dividend, multiplier/divisor)
//   op                 - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   start              - operation request, sampled only in IDLE
//   hi_we, lo_we, wdata- MTHI/MTLO writes, honoured only in IDLE
//   busy               - operation in flight (front-end stall)
//   done, divzero      - one-cycle pulses when HI/LO receive a result
//   hi, lo             - HI/LO register outputs
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2       = 2 * WIDTH;
  localparam logic [4:0]  CNT_LAST = 5'(WIDTH - 1);

  state_t           state;
  logic [4:0]       cnt;
  logic [1:0]       op_q;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mcand;   // multiplicand magnitude or divisor magnitude
  logic [W2-1:0]    prod;    // {acc, multiplier} or {remainder, quotient}

  logic             is_div;
  logic             start_signed;
  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [W2-1:0]    neg_in;
  logic [W2-1:0]    neg_out;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [W2-1:0]    mul_res;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             dz;

  // The single adder and single negator are idle in some states, so they are
  // borrowed there: in IDLE the adder forms -b and the negator forms -a for the
  // operand magnitudes; in FIX the adder negates the remainder while the
  // negator handles the product or the quotient.
  always_comb begin
    is_div       = op_is_div(op_q);
    start_signed = op_is_signed(op);
    add_x        = '0;
    add_y        = '0;
    add_cin      = 1'b0;
    case (state)
      ST_IDLE: begin
        add_x   = {1'b0, ~b};
        add_cin = 1'b1;
      end
      ST_CALC: begin
        if (is_div) begin
          // trial subtract of the divisor from {remainder, next dividend bit}
          add_x   = prod[W2-1:WIDTH-1];
          add_y   = {1'b1, ~mcand};
          add_cin = 1'b1;
        end else begin
          add_x = {1'b0, prod[W2-1:WIDTH]};
          add_y = {1'b0, mcand};
        end
      end
      ST_FIX: begin
        add_x   = {1'b0, ~prod[W2-1:WIDTH]};
        add_cin = 1'b1;
      end
      default: begin
        add_x = '0;
      end
    endcase
    add_sum = add_x + add_y + {{WIDTH{1'b0}}, add_cin};

    if (state == ST_IDLE) begin
      neg_in = {{WIDTH{1'b0}}, a};
    end else if (is_div) begin
      neg_in = {{WIDTH{1'b0}}, prod[WIDTH-1:0]};
    end else begin
      neg_in = prod;
    end
    neg_out = (~neg_in) + {{(W2-1){1'b0}}, 1'b1};

    a_mag   = (start_signed && a[WIDTH-1]) ? neg_out[WIDTH-1:0] : a;
    b_mag   = (start_signed && b[WIDTH-1]) ? add_sum[WIDTH-1:0] : b;
    mul_res = (sign_a ^ sign_b) ? neg_out : prod;
    quo     = (sign_a ^ sign_b) ? neg_out[WIDTH-1:0] : prod[WIDTH-1:0];
    // With a zero divisor every trial subtract succeeds, so the remainder half
    // simply collects |a|; sign correction then restores the original a in HI.
    rem     = sign_a ? add_sum[WIDTH-1:0] : prod[W2-1:WIDTH];
    dz      = is_div && (mcand == '0);
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      op_q    <= OP_MULT;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      mcand   <= '0;
      prod    <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      divzero <= 1'b0;
    end else begin
      done    <= 1'b0;
      divzero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_q   <= op;
            sign_a <= start_signed & a[WIDTH-1];
            sign_b <= start_signed & b[WIDTH-1];
            cnt    <= '0;
            state  <= ST_CALC;
            if (op_is_div(op)) begin
              mcand <= b_mag;
              prod  <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              mcand <= a_mag;
              prod  <= {{WIDTH{1'b0}}, b_mag};
            end
          end
        end
        ST_CALC: begin
          if (is_div) begin
            if (!add_sum[WIDTH]) begin
              prod <= {add_sum[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
            end else begin
              prod <= {prod[W2-2:0], 1'b0};
            end
          end else begin
            if (prod[0]) begin
              prod <= {add_sum, prod[WIDTH-1:1]};
            end else begin
              prod <= {1'b0, prod[W2-1:1]};
            end
          end
          cnt <= cnt + 5'd1;
          if (cnt == CNT_LAST) state <= ST_FIX;
        end
        ST_FIX: begin
          if (is_div) begin
            hi <= rem;
            lo <= dz ? DIVZERO_LO[WIDTH-1:0] : quo;
          end else begin
            hi <= mul_res[W2-1:WIDTH];
            lo <= mul_res[WIDTH-1:0];
          end
          done    <= 1'b1;
          divzero <= dz;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops,
// checked against an arithmetic reference model of HI/LO.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] a, b, wdata;
  logic [1:0]  op;
  logic        start, hi_we, lo_we;
  logic        busy, done, divzero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  // architectural model of HI/LO
  logic [31:0] m_hi, m_lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .op     (op),
    .start  (start),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .divzero(divzero),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input string tag,
                       input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", name, tag, obs, exp);
    end
  endtask

  task automatic ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] eh, output logic [31:0] el, output logic edz);
    logic signed [63:0] sx, sy, sr, sq;
    logic [63:0] ux, uy, ur, uq;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    ux  = {32'b0, x};
    uy  = {32'b0, y};
    edz = 1'b0;
    eh  = '0;
    el  = '0;
    if ((o == OP_DIV || o == OP_DIVU) && y == 32'd0) begin
      eh  = x;
      el  = 32'hFFFFFFFF;
      edz = 1'b1;
    end else begin
      case (o)
        OP_MULT:  begin sr = sx * sy; eh = sr[63:32]; el = sr[31:0]; end
        OP_MULTU: begin ur = ux * uy; eh = ur[63:32]; el = ur[31:0]; end
        OP_DIV:   begin sq = sx / sy; sr = sx % sy; el = sq[31:0]; eh = sr[31:0]; end
        default:  begin uq = ux / uy; ur = ux % uy; el = uq[31:0]; eh = ur[31:0]; end
      endcase
    end
  endtask

  // Ends at the negedge of the done cycle so a caller may start back-to-back.
  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input bit b2b, input bit inject);
    logic [31:0] eh, el;
    logic        edz;
    int          cyc, bcnt;
    ref_op(o, x, y, eh, el, edz);
    if (!b2b) @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc   = 1;
    bcnt  = 0;
    check(name, "busy_after_start", busy, 1);
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      if (inject && cyc == 5) begin
        start = 1'b1; hi_we = 1'b1; wdata = 32'h1234; op = OP_MULTU; a = 2; b = 2;
      end
      if (inject && cyc == 6) begin
        start = 1'b0; hi_we = 1'b0;
      end
      if (cyc == 10) begin
        check(name, "hi_hold", hi, m_hi);
        check(name, "lo_hold", lo, m_lo);
      end
      @(negedge clock);
      cyc++;
    end
    check(name, "done_seen", done, 1);
    check(name, "done_latency", cyc, 34);
    check(name, "busy_cycles", bcnt, 33);
    check(name, "busy_in_done", busy, 0);
    m_hi = eh;
    m_lo = el;
    check(name, "hi", hi, m_hi);
    check(name, "lo", lo, m_lo);
    check(name, "divzero", divzero, edz);
  endtask

  task automatic post_idle(input string name);
    @(negedge clock);
    check(name, "done_pulse_end", done, 0);
    check(name, "divzero_pulse_end", divzero, 0);
    check(name, "idle_after", busy, 0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    bit          saw_done;

    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    wdata = '0; op = OP_MULT; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clock);
    check("reset", "hi", hi, 0);
    check("reset", "lo", lo, 0);
    check("reset", "busy", busy, 0);
    check("reset", "done", done, 0);
    check("reset", "divzero", divzero, 0);
    reset = 1'b0;

    do_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    check("multu_max", "hi_const", hi, 32'hFFFFFFFE);
    check("multu_max", "lo_const", lo, 32'h00000001);
    post_idle("multu_max");

    do_op("mult_neg3x5", OP_MULT, 32'hFFFFFFFD, 32'd5, 0, 0);
    check("mult_neg3x5", "lo_const", lo, 32'hFFFFFFF1);
    do_op("mult_minsq", OP_MULT, 32'h80000000, 32'h80000000, 1, 0);
    check("mult_minsq", "hi_const", hi, 32'h40000000);
    post_idle("mult_minsq");

    do_op("div_neg7by2", OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 0);
    check("div_neg7by2", "lo_const", lo, 32'hFFFFFFFD);
    check("div_neg7by2", "hi_const", hi, 32'hFFFFFFFF);
    do_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 0);
    check("div_ovf", "lo_const", lo, 32'h80000000);
    check("div_ovf", "hi_const", hi, 32'h0);
    post_idle("div_ovf");

    do_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 0, 0);
    check("divu_zero", "hi_const", hi, 32'h64);
    post_idle("divu_zero");
    do_op("div_zero_neg", OP_DIV, 32'hFFFFFF00, 32'd0, 0, 0);
    post_idle("div_zero_neg");

    // start + MTHI while busy are both dropped
    do_op("busy_ignore", OP_MULT, 32'd7, 32'd9, 0, 1);
    post_idle("busy_ignore");

    @(negedge clock);
    lo_we = 1'b1; wdata = 32'hABCD;
    @(negedge clock);
    lo_we = 1'b0;
    m_lo = 32'hABCD;
    check("mtlo", "lo", lo, m_lo);
    check("mtlo", "hi", hi, m_hi);

    // reset in the middle of a DIVU
    @(negedge clock);
    op = OP_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    m_hi = '0; m_lo = '0;
    check("reset_mid", "busy", busy, 0);
    check("reset_mid", "hi", hi, m_hi);
    check("reset_mid", "lo", lo, m_lo);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    reset = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    check("reset_mid", "no_done", saw_done, 0);
    do_op("after_reset", OP_MULTU, 32'd3, 32'd4, 0, 0);
    check("after_reset", "lo_const", lo, 32'd12);
    check("after_reset", "hi_const", hi, 32'd0);
    post_idle("after_reset");

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      case ($urandom_range(0, 7))
        0:       ry = 32'd0;
        1, 2, 3: ry = 32'($urandom_range(1, 1000));
        4:       ry = -32'($urandom_range(1, 1000));
        default: ry = $urandom;
      endcase
      do_op($sformatf("rand%0d", i), ro, rx, ry, (i % 2) == 1, 0);
    end
    post_idle("rand_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
